// File: rtl/soc_sysctl.sv
// Wishbone system-control slave: boot-strap capture, remap override, timed soft reset.
// Optional byte-writable scratch bank is built when SOC_SYSCTL_SCRATCH_EN is defined.
module soc_sysctl #(
    parameter int STRAP_W     = 4,
    parameter int SEL_W       = 2,
    parameter int REMAP_W     = 2,
    parameter int NUM_SCRATCH = 4,
    parameter int RST_PULSE   = 16
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_i,
    input  logic [31:0]        sys_data_i,
    output logic [31:0]        sys_data_o,
    input  logic [31:0]        sys_addr_i,
    input  logic [3:0]         sys_sel_i,
    input  logic               sys_we_i,
    input  logic               sys_cyc_i,
    input  logic               sys_stb_i,
    output logic               sys_ack_o,
    output logic               sys_err_o,
    output logic               sys_rty_o,
    input  logic [STRAP_W-1:0] boot_strap,
    output logic [SEL_W-1:0]   boot_select,
    output logic [REMAP_W-1:0] boot_remap,
    output logic               soft_rst_o
);
    typedef enum logic [1:0] {CAPTURE, RUN, SRST} state_e;
    localparam int CNT_W = $clog2(RST_PULSE);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STRAP_W-1:0] strap_q, strap_d;
    logic               ovr_en_q, ovr_en_d;
    logic [REMAP_W-1:0] ovr_val_q, ovr_val_d;
    logic               ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic [31:0]        rdata_q, rdata_d;
`ifdef SOC_SYSCTL_SCRATCH_EN
    logic [31:0]        scratch_q [NUM_SCRATCH];
    logic [31:0]        scratch_d [NUM_SCRATCH];
`endif

    logic        req, hit, ctl_wr;
    logic [3:0]  off;
    logic [31:0] rd;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        strap_d   = strap_q;
        ovr_en_d  = ovr_en_q;
        ovr_val_d = ovr_val_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rty_d     = 1'b0;
        rdata_d   = 32'h0;
        hit       = 1'b1;
        rd        = 32'h0;
`ifdef SOC_SYSCTL_SCRATCH_EN
        scratch_d = scratch_q;
`endif
        // A new request only exists while no termination is on the bus.
        req    = sys_cyc_i & sys_stb_i & ~(ack_q | err_q | rty_q);
        off    = sys_addr_i[5:2];
        ctl_wr = req & sys_we_i & sys_sel_i[0] & (state_q == RUN);

        case (state_q)
            CAPTURE: begin
                strap_d   = boot_strap;
                ovr_en_d  = 1'b0;
                ovr_val_d = '0;
                state_d   = RUN;
            end
            SRST: begin
                if (cnt_q == '0) state_d = CAPTURE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: ;
        endcase

        case (off)
            4'h0: rd = 32'h5C5C_0002;
            4'h1: rd[STRAP_W-1:0] = strap_q;
            4'h2: begin
                rd[8]         = ovr_en_q;
                rd[REMAP_W-1:0] = ovr_val_q;
                if (ctl_wr) begin
                    ovr_en_d  = sys_data_i[8];
                    ovr_val_d = sys_data_i[REMAP_W-1:0];
                end
            end
            4'h3: begin
                rd[0] = (state_q == SRST);
                if (ctl_wr && sys_data_i[0]) begin
                    state_d = SRST;
                    cnt_d   = CNT_W'(RST_PULSE - 1);
                end
            end
            default: begin
                hit = 1'b0;
`ifdef SOC_SYSCTL_SCRATCH_EN
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (off == 4'(4 + i)) begin
                        hit = 1'b1;
                        rd  = scratch_q[i];
                        if (req && sys_we_i && state_q != CAPTURE) begin
                            for (int b = 0; b < 4; b++)
                                if (sys_sel_i[b]) scratch_d[i][8*b +: 8] = sys_data_i[8*b +: 8];
                        end
                    end
                end
`endif
            end
        endcase

        if (req) begin
            if (state_q == CAPTURE) rty_d = 1'b1;
            else if (hit) begin
                ack_d   = 1'b1;
                rdata_d = sys_we_i ? 32'h0 : rd;
            end else err_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q   <= CAPTURE;
            cnt_q     <= '0;
            strap_q   <= '0;
            ovr_en_q  <= 1'b0;
            ovr_val_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rty_q     <= 1'b0;
            rdata_q   <= 32'h0;
`ifdef SOC_SYSCTL_SCRATCH_EN
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= 32'h0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            strap_q   <= strap_d;
            ovr_en_q  <= ovr_en_d;
            ovr_val_q <= ovr_val_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rty_q     <= rty_d;
            rdata_q   <= rdata_d;
`ifdef SOC_SYSCTL_SCRATCH_EN
            scratch_q <= scratch_d;
`endif
        end
    end

    assign sys_data_o  = rdata_q;
    assign sys_ack_o   = ack_q;
    assign sys_err_o   = err_q;
    assign sys_rty_o   = rty_q;
    assign soft_rst_o  = (state_q == SRST);
    assign boot_select = strap_q[STRAP_W-1:REMAP_W];
    assign boot_remap  = ovr_en_q ? ovr_val_q : strap_q[REMAP_W-1:0];

    // Address bits outside [5:2] and upper data/lane bits are don't-care in some builds.
    logic unused_bits;
    assign unused_bits = ^{sys_addr_i[31:6], sys_addr_i[1:0], sys_data_i, sys_sel_i};
endmodule

// File: doc/soc_sysctl.md
# soc_sysctl

Parametrised system-control slave on the SoC Wishbone bus. It captures the boot-strap pins after reset and drives the boot select and remap outputs. It adds a software-writable remap override, a timed soft-reset pulse generator that re-captures the straps, and an optional bank of byte-writable scratch registers. It sits behind the system address decoder as the next-generation replacement for the fixed 4-bit strap/register block.

## Interface

- STRAP_W, 4: boot_strap width; must equal SEL_W + REMAP_W.
- SEL_W, 2: boot_select width, taken from strap bits [STRAP_W-1:REMAP_W].
- REMAP_W, 2: boot_remap width, taken from strap bits [REMAP_W-1:0]; maximum 8.
- NUM_SCRATCH, 4: scratch register count; 1..12.
- RST_PULSE, 16: soft_rst_o length in clocks; minimum 2.

Ports:

- sys_clk_i  in  1  sole clock, rising edge.
- sys_rst_i  in  1  reset. **Asynchronous, active-high.**
- sys_data_i  in  32  write data.
- sys_data_o  out  32  read data; valid while sys_ack_o is high, 0 otherwise.
- sys_addr_i  in  32  byte address; only bits [5:2] are decoded.
- sys_sel_i  in  4  byte lanes.
- sys_we_i  in  1  write enable.
- sys_cyc_i, sys_stb_i  in  1  Wishbone cycle and strobe.
- sys_ack_o, sys_err_o, sys_rty_o  out  1  termination signals; one-cycle pulses, mutually exclusive.
- boot_strap  in  STRAP_W  strap pins, static around reset.
- boot_select  out  SEL_W  captured select field.
- boot_remap  out  REMAP_W  effective remap value.
- soft_rst_o  out  1  soft-reset request to the rest of the SoC.

## Operation

- **FSM states:** CAPTURE, RUN, SRST. Reset forces CAPTURE.
- **CAPTURE:** lasts exactly one clock.
  - Samples boot_strap into strap_r.
  - Clears CTRL.
  - Moves to RUN.
- **RUN:** normal bus operation. A write with bit0=1 to SOFTRST moves to SRST and loads the counter with RST_PULSE-1.
- **SRST:**
  - soft_rst_o is high and the counter decrements each clock.
  - When the counter reaches 0, the FSM moves to CAPTURE.
  - Scratch contents survive a soft reset.
- **Register map (word offsets):**
  - 0x0 ID: read-only 0x5C5C_0002.
  - 0x1 STRAP: read-only, strap_r zero-extended.
  - 0x2 CTRL: R/W. Bits [REMAP_W-1:0] hold the override value and bit 8 is the override enable. Other bits read 0.
  - 0x3 SOFTRST: a write with bit0=1 triggers a soft reset; bit0 reads back 1 while in SRST.
  - 0x4..0x4+NUM_SCRATCH-1 SCRATCH: 32-bit R/W, writes honour sys_sel_i per byte.
- **Outputs:**
  - boot_remap = CTRL[8] ? CTRL[REMAP_W-1:0] : strap_r[REMAP_W-1:0].
  - boot_select = strap_r[STRAP_W-1:REMAP_W].
- **Termination rules:**
  - Unmapped offset → err. Nothing is written and data is 0.
  - Any access while the FSM is in CAPTURE → rty.
  - Access while in SRST:
    - reads → ack;
    - writes to SOFTRST → ack with no effect (no retrigger);
    - writes to CTRL → ack but discarded;
    - scratch writes → ack and take effect.
  - CTRL/SOFTRST writes ignore sys_sel_i, except that byte 0 (sys_sel_i[0]) is required. A write with sys_sel_i[0]=0 → ack, no effect.

## Timing

- **Reset values:** every output is 0, strap_r=0, CTRL=0, scratch=0, state=CAPTURE.
  - boot_select and boot_remap are therefore 0 during reset and until the CAPTURE edge.
- **Strap capture:** strap_r becomes valid after the first rising edge following sys_rst_i deassertion. The outputs update on that same edge.
- **Bus handshake:**
  - A request is cyc&stb with no termination currently asserted.
  - It is registered at edge k; ack, err or rty goes high after edge k and drops after edge k+1.
  - Back-to-back accesses therefore take 2 clocks each. The master must drop stb, or present a new request, after the termination.
- **Write latency:** the write takes effect at the same edge that raises ack.
  - boot_remap changes on that edge.
  - soft_rst_o rises on that edge.
- **soft_rst_o:** high for exactly RST_PULSE clocks, followed by 1 CAPTURE clock, then RUN.
- **Reset mid-pulse:** an asynchronous reset aborts the pulse immediately and drops soft_rst_o.
- **Mid-access abort:** a termination pending when cyc drops is still driven for one cycle, and the bus ignores it.

## Configuration

- **SOC_SYSCTL_SCRATCH_EN defined:** scratch bank present as above.
- **SOC_SYSCTL_SCRATCH_EN undefined:** no scratch storage. Offsets 0x4 and up → err; NUM_SCRATCH is ignored.

## Test plan

- **Strap capture:** hold boot_strap=4'b1001, release reset → boot_select=2'b10 and boot_remap=2'b01 after the first edge. An access in that first cycle gets rty; a STRAP read afterwards returns 0x9.
- **Remap override:** write CTRL=0x0000_0103 → boot_remap=2'b11 on the ack edge. Write CTRL=0x0 → boot_remap returns to 2'b01.
- **Soft reset:** change boot_strap to 4'b0110, write SOFTRST=1 → soft_rst_o high for exactly 16 clocks. After the following CAPTURE cycle: boot_select=2'b01, boot_remap=2'b10, CTRL=0. A second SOFTRST write during the pulse does not extend it.
- **Scratch bytes:** write 0xDEADBEEF to offset 0x4, then 0x0000_1200 with sel=4'b0010 → read returns 0xDEAD12EF. A soft reset leaves the value intact.
- **Error path:** read offset 0xF → err pulse, sys_data_o=0. With the macro undefined, offset 0x4 → err.
- **Async reset:** assert sys_rst_i mid-pulse → soft_rst_o and all outputs are 0 immediately, without waiting for a clock edge.
